// File: rtl/mem_pkg.sv
// mem_pkg: constants and helpers shared by the data-memory responder.
//   - RV32I funct3 access-size encodings (F3_B .. F3_HU)
//   - responder FSM state encoding
//   - default RAM depth (log2 of the number of 32-bit words)
//   - sign/zero extension helpers for byte and half loads
package mem_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  // Extend a byte to 32 bits; sign-extend when is_signed is set.
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_signed);
    return {{24{is_signed & b[7]}}, b};
  endfunction

  // Extend a half-word to 32 bits; sign-extend when is_signed is set.
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_signed);
    return {{16{is_signed & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for RV32I loads/stores.
// Ports:
//   funct3   in  access size/sign
//   byte_off in  addr[1:0], byte lane within the word
//   wdata    in  store data (rs2), value in the low bits
//   raw_word in  current 32-bit RAM word
//   byte_en  out lanes to write (0 when faulted)
//   wr_word  out store data replicated onto every candidate lane
//   ld_value out selected byte/half/word shifted to bit 0 and extended
//   fault    out misaligned access or unsupported funct3
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] ld_value,
  output logic        fault
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and half out of the raw word.
  always_comb begin
    sel_byte = 8'h00;
    case (byte_off)
      2'd0:    sel_byte = raw_word[7:0];
      2'd1:    sel_byte = raw_word[15:8];
      2'd2:    sel_byte = raw_word[23:16];
      2'd3:    sel_byte = raw_word[31:24];
      default: sel_byte = 8'h00;
    endcase
    if (byte_off[1]) begin
      sel_half = raw_word[31:16];
    end else begin
      sel_half = raw_word[15:0];
    end
  end

  // Size decode: enables, replicated write data, extended load, fault.
  always_comb begin
    byte_en  = 4'b0000;
    wr_word  = 32'h0000_0000;
    ld_value = 32'h0000_0000;
    fault    = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en  = 4'b0001 << byte_off;
        wr_word  = {4{wdata[7:0]}};
        // funct3[2] clear means the signed variant
        ld_value = ext_byte(sel_byte, ~funct3[2]);
      end
      F3_H, F3_HU: begin
        wr_word  = {2{wdata[15:0]}};
        ld_value = ext_half(sel_half, ~funct3[2]);
        if (byte_off[0]) begin
          fault = 1'b1;
        end else begin
          byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
        end
      end
      F3_W: begin
        wr_word  = wdata;
        ld_value = raw_word;
        if (byte_off != 2'b00) begin
          fault = 1'b1;
        end else begin
          byte_en = 4'b1111;
        end
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage responder for loads/stores from decode.
// Performs one access per request on an internal word-organised RAM after a
// programmable number of wait states, holding the pipeline with busy.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   mem_read_en      load request
//   mem_write_en     store request (wins when both enables are high)
//   funct3           RV32I access size/sign
//   addr             byte address; upper bits alias
//   wdata            store data
//   rdata            extended load result, 0 outside the response cycle
//   rdata_valid      load response cycle
//   busy             stall request to the pipeline
//   misaligned_err   one-cycle pulse for a faulted access
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        misaligned_err
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);

  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  op_write_q, op_write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic                  err_q, err_d;

  logic [31:0]           ram_q [DEPTH];

  logic                  req;
  logic                  acc_write;
  logic [2:0]            acc_funct3;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic [31:0]           raw_word;
  logic [3:0]            byte_en;
  logic [31:0]           wr_word;
  logic [31:0]           ld_value;
  logic                  lane_fault;
  logic                  fault;
  logic                  enter_resp;
  logic                  ram_we;
  logic                  unused_addr_hi;

  assign req            = mem_read_en | mem_write_en;
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  // With zero wait states the RAM access happens on the accepting edge, so
  // the operands come straight from the inputs while idle; otherwise from
  // the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write  = mem_write_en;
      acc_funct3 = funct3;
      acc_addr   = addr[ADDR_WIDTH+1:0];
      acc_wdata  = wdata;
    end else begin
      acc_write  = op_write_q;
      acc_funct3 = funct3_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
  end

  assign raw_word = ram_q[acc_addr[ADDR_WIDTH+1:2]];

  mem_lane_align u_lane_align (
    .funct3   (acc_funct3),
    .byte_off (acc_addr[1:0]),
    .wdata    (acc_wdata),
    .raw_word (raw_word),
    .byte_en  (byte_en),
    .wr_word  (wr_word),
    .ld_value (ld_value),
    .fault    (lane_fault)
  );

  // Unsigned sizes exist only for loads.
  assign fault = lane_fault | (acc_write & acc_funct3[2]);

  // FSM next state, wait counter and request latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_write_d = mem_write_en;
          funct3_d   = funct3;
          addr_d     = addr[ADDR_WIDTH+1:0];
          wdata_d    = wdata;
          if (NO_WAIT) begin
            state_d = S_RESPOND;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_RESPOND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // The access commits and the response is captured on the edge entering
  // RESPOND; reset on that edge cancels both.
  assign enter_resp = (state_d == S_RESPOND) && (state_q != S_RESPOND);
  assign ram_we     = enter_resp & acc_write & ~fault & ~reset;

  // Registered response values, all zero outside the response cycle.
  always_comb begin
    rdata_d       = 32'h0000_0000;
    rdata_valid_d = 1'b0;
    err_d         = 1'b0;
    if (enter_resp) begin
      rdata_valid_d = ~acc_write;
      err_d         = fault;
      if (!acc_write && !fault) begin
        rdata_d = ld_value;
      end else begin
        rdata_d = 32'h0000_0000;
      end
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // Stall: combinational request while idle, held through the wait states.
  always_comb begin
    case (state_q)
      S_IDLE:    busy = req;
      S_WAIT:    busy = 1'b1;
      S_RESPOND: busy = 1'b0;
      default:   busy = 1'b0;
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 3'd0;
      op_write_q    <= 1'b0;
      funct3_q      <= 3'b000;
      addr_q        <= '0;
      wdata_q       <= 32'h0000_0000;
      rdata_q       <= 32'h0000_0000;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_write_q    <= op_write_d;
      funct3_q      <= funct3_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  // Byte-enabled RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          ram_q[acc_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= wr_word[8*i +: 8];
        end
      end
    end
  end

  assign rdata          = rdata_q;
  assign rdata_valid    = rdata_valid_q;
  assign misaligned_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder. Three instances:
// index 0 WAIT_STATES=1, index 1 WAIT_STATES=3, index 2 WAIT_STATES=0.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        valid;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        rd_en   [3];
  logic        wr_en   [3];
  logic [2:0]  f3_i    [3];
  logic [31:0] addr_i  [3];
  logic [31:0] wdata_i [3];
  logic [31:0] rdata_o [3];
  logic        valid_o [3];
  logic        busy_o  [3];
  logic        err_o   [3];

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .reset(reset), .mem_read_en(rd_en[0]), .mem_write_en(wr_en[0]),
    .funct3(f3_i[0]), .addr(addr_i[0]), .wdata(wdata_i[0]), .rdata(rdata_o[0]),
    .rdata_valid(valid_o[0]), .busy(busy_o[0]), .misaligned_err(err_o[0]));

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .reset(reset), .mem_read_en(rd_en[1]), .mem_write_en(wr_en[1]),
    .funct3(f3_i[1]), .addr(addr_i[1]), .wdata(wdata_i[1]), .rdata(rdata_o[1]),
    .rdata_valid(valid_o[1]), .busy(busy_o[1]), .misaligned_err(err_o[1]));

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(reset), .mem_read_en(rd_en[2]), .mem_write_en(wr_en[2]),
    .funct3(f3_i[2]), .addr(addr_i[2]), .wdata(wdata_i[2]), .rdata(rdata_o[2]),
    .rdata_valid(valid_o[2]), .busy(busy_o[2]), .misaligned_err(err_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int k);
    rd_en[k] = 1'b0; wr_en[k] = 1'b0; f3_i[k] = 3'b000;
    addr_i[k] = 32'h0; wdata_i[k] = 32'h0;
  endtask

  // One access: drive at a falling edge, measure busy length, compare the
  // response cycle against the scoreboard, then confirm outputs clear.
  task automatic access(input string tag, input int k, input bit rd, input bit wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input bit exp_valid, input bit exp_err);
    exp_t e;
    int   c;
    e.rdata = exp_rdata; e.valid = exp_valid; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    rd_en[k] = rd; wr_en[k] = wr; f3_i[k] = f3; addr_i[k] = a; wdata_i[k] = wd;
    #1;
    chk({tag, "_busy_c0"}, 32'(busy_o[k]), 32'd1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (busy_o[k] && c < 20);
    chk({tag, "_latency"}, 32'(c), 32'(ws_of(k) + 1));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, rdata_o[k], e.rdata);
      chk({tag, "_valid"}, 32'(valid_o[k]), 32'(e.valid));
      chk({tag, "_err"},   32'(err_o[k]),   32'(e.err));
    end
    @(negedge clk);
    idle_inputs(k);
    #1;
    chk({tag, "_post_rdata"}, rdata_o[k], 32'h0);
    chk({tag, "_post_valid"}, 32'(valid_o[k]), 32'd0);
    chk({tag, "_post_err"},   32'(err_o[k]),   32'd0);
    chk({tag, "_post_busy"},  32'(busy_o[k]),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) idle_inputs(k);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata_o[k], 32'h0);
      chk("rst_valid", 32'(valid_o[k]), 32'd0);
      chk("rst_busy",  32'(busy_o[k]),  32'd0);
      chk("rst_err",   32'(err_o[k]),   32'd0);
    end

    // WAIT_STATES=1: word store/load and extension
    access("sw10",    0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    access("lw10",    0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    access("lb13",    0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b1, 1'b0);
    access("lbu13",   0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b1, 1'b0);
    access("lh12",    0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b1, 1'b0);
    access("lhu10",   0, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b1, 1'b0);
    // byte-lane store
    access("sb11",    0, 1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0, 1'b0);
    access("lw10_sb", 0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b1, 1'b0);
    // misalignment
    access("lw12_mis", 0, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1'b1);
    access("sh11_mis", 0, 1'b0, 1'b1, 3'b001, 32'h11, 32'h1234, 32'h0, 1'b0, 1'b1);
    access("lw10_mis", 0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b1, 1'b0);
    // both enables -> store; unsigned-size store faults; aliasing
    access("both20",  0, 1'b1, 1'b1, 3'b010, 32'h20, 32'h5, 32'h0, 1'b0, 1'b0);
    access("lw20",    0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h5, 1'b1, 1'b0);
    access("sbu20",   0, 1'b0, 1'b1, 3'b100, 32'h20, 32'h9, 32'h0, 1'b0, 1'b1);
    access("lw1020",  0, 1'b1, 1'b0, 3'b010, 32'h1020, 32'h0, 32'h5, 1'b1, 1'b0);
    access("lil20",   0, 1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1);

    // WAIT_STATES=3: reset abandons an in-flight store
    access("sw30_old", 1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h11111111, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    wr_en[1] = 1'b1; f3_i[1] = 3'b010; addr_i[1] = 32'h30; wdata_i[1] = 32'h22222222;
    @(negedge clk);
    chk("rstmid_busy_c1", 32'(busy_o[1]), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs(1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid_busy_c3", 32'(busy_o[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_no_err",   32'(err_o[1]),   32'd0);
      chk("rstmid_no_valid", 32'(valid_o[1]), 32'd0);
    end
    access("lw30_old", 1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'h11111111, 1'b1, 1'b0);

    // WAIT_STATES=0
    access("ws0_sw40",  2, 1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    access("ws0_lw40",  2, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
    access("ws0_lhu42", 2, 1'b1, 1'b0, 3'b101, 32'h42, 32'h0, 32'h0000CAFE, 1'b1, 1'b0);
    access("ws0_sh42",  2, 1'b0, 1'b1, 3'b001, 32'h42, 32'h00008001, 32'h0, 1'b0, 1'b0);
    access("ws0_lh42",  2, 1'b1, 1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFF8001, 1'b1, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
